// File: rtl/memory_ram_banked.sv
// rtl/memory_ram_banked.sv - byte-banked RAM with valid/ready request/response ports
// Optional MEMORY_RAM_BANKED_MISALIGN_ERR_EN: misaligned requests answer with o_rsp_err=1 and no effect.
module memory_ram_banked #(
  parameter int DEPTH  = 4096,
  parameter int NBYTES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic                     i_wren,
  input  logic [NBYTES-1:0]        i_bmask,
  input  logic [8*NBYTES-1:0]      i_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [8*NBYTES-1:0]      o_rdata,
  output logic                     o_rsp_err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int OW   = $clog2(NBYTES);
  localparam int RW   = AW - OW;
  localparam int ROWS = DEPTH / NBYTES;

  logic [7:0]          mem_q [NBYTES][ROWS];
  logic [OW-1:0]       off;
  logic [RW-1:0]       row_base;
  logic [RW-1:0]       bank_row [NBYTES];
  logic [7:0]          wr_lane [NBYTES];
  logic [7:0]          wr_bank [NBYTES];
  logic [NBYTES-1:0]   wr_en;
  logic [7:0]          rd_bank [NBYTES];
  logic [8*NBYTES-1:0] rd_word;
  logic                accept;
  logic                misaligned_err;

  logic                rsp_valid_q, rsp_valid_d;
  logic [8*NBYTES-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;

`ifdef MEMORY_RAM_BANKED_MISALIGN_ERR_EN
  assign misaligned_err = (off != '0);
`else
  assign misaligned_err = 1'b0;
`endif

  assign o_req_ready = ~rsp_valid_q | i_rsp_ready;
  assign accept      = i_req_valid & o_req_ready & ~i_reset;

  // Banks below the lane-0 offset hold the bytes that spilled into the next row.
  always_comb begin
    off      = i_addr[OW-1:0];
    row_base = i_addr[AW-1:OW];
    for (int k = 0; k < NBYTES; k++) begin
      wr_lane[k] = i_wdata[8*k +: 8];
    end
    for (int b = 0; b < NBYTES; b++) begin
      bank_row[b] = (OW'(b) < off) ? row_base + RW'(1) : row_base;
      wr_bank[b]  = wr_lane[OW'(b) - off];
      wr_en[b]    = accept & i_wren & ~misaligned_err & i_bmask[OW'(b) - off];
      rd_bank[b]  = mem_q[b][bank_row[b]];
    end
    for (int k = 0; k < NBYTES; k++) begin
      rd_word[8*k +: 8] = rd_bank[OW'(k) + off];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_en[b]) begin
        mem_q[b][bank_row[b]] <= wr_bank[b];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      err_d       = misaligned_err;
      rdata_d     = (i_wren | misaligned_err) ? '0 : rd_word;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rdata     = rdata_q;
  assign o_rsp_err   = err_q;

endmodule
